// File: rtl/roberto_uc.sv
// roberto_uc: once-per-second measure-and-report sequencer for three HC-SR04 sensors and a serial tx.
// Define ROBERTO_UC_WATCHDOG_EN to enable the AGUARDA watchdog and the sticky erro flags.
module roberto_uc #(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter int unsigned TMO_W          = 22
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pronto_seg,
  input  logic       pronto_medida1,
  input  logic       pronto_medida2,
  input  logic       pronto_medida3,
  input  logic       pronto_serial,
  output logic       zera_sensor,
  output logic       zera_serial,
  output logic       zera_seg,
  output logic       cont_seg,
  output logic       medir,
  output logic       partida_tx,
  output logic [1:0] sel_sensor,
  output logic [1:0] sel_char,
  output logic [2:0] erro,
  output logic       fim_ciclo,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARA    = 4'd1,
    ESPERA_SEG = 4'd2,
    MEDE       = 4'd3,
    AGUARDA    = 4'd4,
    TRANSMITE  = 4'd5,
    ESPERA_TX  = 4'd6,
    PROXIMO    = 4'd7,
    FIM        = 4'd8
  } state_e;

  if (TIMEOUT_CYCLES < 2 || (TIMEOUT_CYCLES >> TMO_W) != 0) begin : g_param_chk
    $error("roberto_uc: TIMEOUT_CYCLES must be >= 2 and fit in TMO_W bits");
  end

  state_e     state_q, state_d;
  logic [1:0] sel_sensor_q, sel_sensor_d;
  logic [1:0] sel_char_q, sel_char_d;
  logic [2:0] done_q, done_d;
  logic [2:0] done_all_c;
  logic       wd_expired_c;

  // This cycle's pulses count as done, so a late pulse still beats the watchdog.
  assign done_all_c = done_q | {pronto_medida3, pronto_medida2, pronto_medida1};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= INICIAL;
      sel_sensor_q <= 2'd0;
      sel_char_q   <= 2'd3;
      done_q       <= 3'b000;
    end else begin
      state_q      <= state_d;
      sel_sensor_q <= sel_sensor_d;
      sel_char_q   <= sel_char_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_sensor_d = sel_sensor_q;
    sel_char_d   = sel_char_q;
    done_d       = done_q;
    case (state_q)
      INICIAL: if (ligar) state_d = PREPARA;
      PREPARA: begin
        done_d       = 3'b000;
        sel_sensor_d = 2'd0;
        sel_char_d   = 2'd3;
        state_d      = ESPERA_SEG;
      end
      ESPERA_SEG: begin
        if (!ligar)          state_d = INICIAL;
        else if (pronto_seg) state_d = MEDE;
      end
      MEDE: begin
        done_d  = 3'b000;
        state_d = AGUARDA;
      end
      AGUARDA: begin
        done_d = done_all_c;
        if (&done_all_c || wd_expired_c) state_d = TRANSMITE;
      end
      TRANSMITE: state_d = ESPERA_TX;
      ESPERA_TX: if (pronto_serial) state_d = PROXIMO;
      // Walk chars 3..0 within a sensor, then advance the sensor.
      PROXIMO: begin
        if (sel_char_q != 2'd0) begin
          sel_char_d = sel_char_q - 2'd1;
          state_d    = TRANSMITE;
        end else if (sel_sensor_q < 2'd2) begin
          sel_sensor_d = sel_sensor_q + 2'd1;
          sel_char_d   = 2'd3;
          state_d      = TRANSMITE;
        end else begin
          sel_sensor_d = 2'd0;
          sel_char_d   = 2'd3;
          state_d      = FIM;
        end
      end
      FIM:     state_d = ESPERA_SEG;
      default: state_d = INICIAL;
    endcase
  end

`ifdef ROBERTO_UC_WATCHDOG_EN
  logic [TMO_W-1:0] wd_q, wd_d;
  logic [2:0]       erro_q, erro_d;

  assign wd_expired_c = (wd_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      wd_q   <= '0;
      erro_q <= 3'b000;
    end else begin
      wd_q   <= wd_d;
      erro_q <= erro_d;
    end
  end

  // Sensors still missing when the window closes are flagged until the next PREPARA.
  always_comb begin
    wd_d   = wd_q;
    erro_d = erro_q;
    case (state_q)
      PREPARA: erro_d = 3'b000;
      MEDE:    wd_d   = '0;
      AGUARDA: begin
        wd_d = wd_q + TMO_W'(1);
        if (wd_expired_c && !(&done_all_c)) erro_d = erro_q | ~done_all_c;
      end
      default: ;
    endcase
  end

  assign erro = erro_q;
`else
  assign wd_expired_c = 1'b0;
  assign erro         = 3'b000;
`endif

  assign zera_sensor = (state_q == PREPARA);
  assign zera_serial = (state_q == PREPARA);
  assign zera_seg    = (state_q == PREPARA);
  assign cont_seg    = (state_q == ESPERA_SEG);
  assign medir       = (state_q == MEDE);
  assign partida_tx  = (state_q == TRANSMITE);
  assign fim_ciclo   = (state_q == FIM);
  assign sel_sensor  = sel_sensor_q;
  assign sel_char    = sel_char_q;
  assign db_estado   = state_q;

endmodule
